// File: rtl/text_mem_pkg.sv
// Shared types and defaults for the text buffer RAM arbiter.
package text_mem_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 12;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_MEM_DEPTH  = 2400;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam logic [7:0]  DEF_CLEAR_CHAR = 8'h20;

    // Who owns the RAM read data returning next cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VGA  = 2'd1,
        OWN_CPU  = 2'd2
    } owner_e;

    // Clear engine state
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/cpu_req_fifo.sv
// Small synchronous FIFO holding queued CPU requests {we, addr, wdata}.
module cpu_req_fifo #(
    parameter int unsigned WIDTH = 21,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses pushes even when a pop happens the same cycle
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = store[rd_ptr];

    // Pointer and occupancy tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= din;
    end

endmodule

// File: rtl/text_mem_arbiter.sv
// Arbitrates the single-port text RAM between VGA scan-out, the clear engine
// and queued CPU requests, and steers read data back to its requester.
module text_mem_arbiter
    import text_mem_pkg::*;
#(
    parameter int unsigned          ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned          DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned          MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int unsigned          FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter logic [DATA_WIDTH-1:0] CLEAR_CHAR = DEF_CLEAR_CHAR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  vga_req,
    input  logic [ADDR_WIDTH-1:0] vga_addr,
    output logic [DATA_WIDTH-1:0] vga_data,
    output logic                  vga_data_valid,
    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_rsp_valid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam int unsigned         REQ_W     = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    state_e                state;
    owner_e                owner;
    logic [ADDR_WIDTH-1:0] clear_cnt;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic [REQ_W-1:0]      head;
    logic                  head_we;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_wdata;

    logic                  vga_win;
    logic                  clr_win;
    logic                  cpu_win;

    assign {head_we, head_addr, head_wdata} = head;

    // Grant priority: VGA, then clear engine, then FIFO head (only when idle)
    assign vga_win = rst_n && vga_req;
    assign clr_win = rst_n && !vga_req && (state == ST_CLEAR);
    assign cpu_win = rst_n && !vga_req && (state == ST_IDLE) && !fifo_empty;

    assign cpu_req_ready  = !fifo_full;
    assign vga_data       = mem_dout;
    assign cpu_rdata      = mem_dout;
    assign vga_data_valid = (owner == OWN_VGA);
    assign cpu_rsp_valid  = (owner == OWN_CPU);

    cpu_req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cpu_req_valid),
        .din   ({cpu_we, cpu_addr, cpu_wdata}),
        .pop   (cpu_win),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // RAM pin mux driven from the winning requester
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (vga_win) begin
            mem_en   = 1'b1;
            mem_addr = vga_addr;
        end else if (clr_win) begin
            mem_en   = 1'b1;
            mem_we   = 1'b1;
            mem_addr = clear_cnt;
            mem_din  = CLEAR_CHAR;
        end else if (cpu_win) begin
            mem_en   = 1'b1;
            mem_we   = head_we;
            mem_addr = head_addr;
            mem_din  = head_wdata;
        end
    end

    // Clear engine FSM and read-owner tag for next-cycle data steering
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            clear_cnt  <= '0;
            clear_busy <= 1'b0;
            owner      <= OWN_NONE;
        end else begin
            if (vga_win)                  owner <= OWN_VGA;
            else if (cpu_win && !head_we) owner <= OWN_CPU;
            else                          owner <= OWN_NONE;

            case (state)
                ST_IDLE: begin
                    if (clear_start) begin
                        state      <= ST_CLEAR;
                        clear_cnt  <= '0;
                        clear_busy <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (clr_win) begin
                        if (clear_cnt == LAST_ADDR) begin
                            state      <= ST_IDLE;
                            clear_cnt  <= '0;
                            clear_busy <= 1'b0;
                        end else begin
                            clear_cnt <= clear_cnt + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_text_mem_arbiter.sv
// Self-checking bench for text_mem_arbiter with a behavioural text RAM.
module tb_text_mem_arbiter;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 8;
    localparam int unsigned MD = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          vga_req = 1'b0;
    logic [AW-1:0] vga_addr = '0;
    logic [DW-1:0] vga_data;
    logic          vga_data_valid;
    logic          cpu_req_valid = 1'b0;
    logic          cpu_req_ready;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_rsp_valid;
    logic [DW-1:0] cpu_rdata;
    logic          clear_start = 1'b0;
    logic          clear_busy;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout = '0;

    logic [DW-1:0] ram     [4096];
    logic [DW-1:0] ref_mem [4096];
    logic [DW-1:0] exp_cpu_q[$];
    logic [DW-1:0] exp_vga_q[$];

    int total = 0;
    int bad   = 0;

    text_mem_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (MD),
        .FIFO_DEPTH (4),
        .CLEAR_CHAR (8'h20)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .vga_req        (vga_req),
        .vga_addr       (vga_addr),
        .vga_data       (vga_data),
        .vga_data_valid (vga_data_valid),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_rsp_valid  (cpu_rsp_valid),
        .cpu_rdata      (cpu_rdata),
        .clear_start    (clear_start),
        .clear_busy     (clear_busy),
        .mem_en         (mem_en),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout)
    );

    always #5 clk = ~clk;

    // Read-first single-port RAM with one cycle read latency
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_din;
            mem_dout <= ram[mem_addr];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        vga_req       = 1'b0;
        cpu_req_valid = 1'b0;
        cpu_we        = 1'b0;
        clear_start   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        step();
        step();
        #1;
        total++; if (vga_data_valid !== 1'b0) begin bad++; $display("FAIL reset_vga_valid got=%b want=0", vga_data_valid); end
        total++; if (cpu_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", cpu_rsp_valid); end
        total++; if (cpu_req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cpu_req_ready); end
        total++; if (clear_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", clear_busy); end
        total++; if ({mem_en, mem_we, mem_addr, mem_din} !== '0) begin bad++; $display("FAIL reset_mem got=%b/%b/%h/%h want=0", mem_en, mem_we, mem_addr, mem_din); end
        total++; if (vga_data !== 8'h00) begin bad++; $display("FAIL reset_vga_data got=%h want=00", vga_data); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_vga_read();
        vga_req  = 1'b1;
        vga_addr = 12'd5;
        #1;
        total++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 12'd5}) begin bad++; $display("FAIL vga_issue got=%b/%b/%0d want=1/0/5", mem_en, mem_we, mem_addr); end
        exp_vga_q.push_back(8'h41);
        step();
        vga_req = 1'b0;
        #1;
        total++; if (vga_data_valid !== 1'b1) begin bad++; $display("FAIL vga_valid got=%b want=1", vga_data_valid); end
        if (exp_vga_q.size() > 0) begin
            logic [DW-1:0] e;
            e = exp_vga_q.pop_front();
            total++; if (vga_data !== e) begin bad++; $display("FAIL vga_data got=%h want=%h", vga_data, e); end
        end
        total++; if (cpu_rsp_valid !== 1'b0) begin bad++; $display("FAIL vga_no_cpu_rsp got=%b want=0", cpu_rsp_valid); end
        step();
    endtask

    task automatic test_cpu_under_vga();
        logic [DW-1:0] e;
        for (int c = 0; c < 3; c++) begin
            vga_req       = 1'b1;
            vga_addr      = 12'd0;
            cpu_req_valid = (c < 2);
            cpu_we        = (c == 0);
            cpu_addr      = 12'd10;
            cpu_wdata     = 8'h42;
            #1;
            total++; if (mem_we !== 1'b0 || mem_addr !== 12'd0) begin bad++; $display("FAIL cpu_blocked_c%0d got we=%b addr=%0d want 0/0", c, mem_we, mem_addr); end
            step();
        end
        idle_inputs();
        #1;
        total++; if ({mem_en, mem_we, mem_addr, mem_din} !== {1'b1, 1'b1, 12'd10, 8'h42}) begin bad++; $display("FAIL cpu_write_issue got=%b/%b/%0d/%h want=1/1/10/42", mem_en, mem_we, mem_addr, mem_din); end
        step();
        #1;
        total++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 12'd10}) begin bad++; $display("FAIL cpu_read_issue got=%b/%b/%0d want=1/0/10", mem_en, mem_we, mem_addr); end
        total++; if (cpu_rsp_valid !== 1'b0) begin bad++; $display("FAIL cpu_write_silent got=%b want=0", cpu_rsp_valid); end
        exp_cpu_q.push_back(8'h42);
        step();
        total++; if (cpu_rsp_valid !== 1'b1) begin bad++; $display("FAIL cpu_rsp_valid got=%b want=1", cpu_rsp_valid); end
        if (exp_cpu_q.size() > 0) begin
            e = exp_cpu_q.pop_front();
            total++; if (cpu_rdata !== e) begin bad++; $display("FAIL cpu_raw_data got=%h want=%h", cpu_rdata, e); end
        end
        step();
    endtask

    task automatic test_fifo_full();
        logic [DW-1:0] e;
        for (int i = 0; i < 5; i++) begin
            vga_req       = 1'b1;
            vga_addr      = 12'd0;
            cpu_req_valid = 1'b1;
            cpu_we        = 1'b0;
            cpu_addr      = AW'(20 + i);
            #1;
            total++; if (cpu_req_ready !== (i < 4)) begin bad++; $display("FAIL fifo_ready_%0d got=%b want=%b", i, cpu_req_ready, (i < 4)); end
            step();
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, AW'(20 + i)}) begin bad++; $display("FAIL drain_issue_%0d got=%b/%b/%0d want=1/0/%0d", i, mem_en, mem_we, mem_addr, 20 + i); end
            exp_cpu_q.push_back(8'h60 + 8'(i));
            step();
            total++; if (cpu_rsp_valid !== 1'b1) begin bad++; $display("FAIL drain_rsp_%0d got=%b want=1", i, cpu_rsp_valid); end
            if (exp_cpu_q.size() > 0) begin
                e = exp_cpu_q.pop_front();
                total++; if (cpu_rdata !== e) begin bad++; $display("FAIL drain_data_%0d got=%h want=%h", i, cpu_rdata, e); end
            end
        end
        #1;
        total++; if (mem_en !== 1'b0 || cpu_req_ready !== 1'b1) begin bad++; $display("FAIL drain_empty got en=%b ready=%b want 0/1", mem_en, cpu_req_ready); end
        step();
    endtask

    task automatic test_clear();
        int k;
        int cyc;
        logic [DW-1:0] e;
        k   = 0;
        cyc = 0;
        clear_start = 1'b1;
        #1;
        total++; if (clear_busy !== 1'b0 || mem_en !== 1'b0) begin bad++; $display("FAIL clear_pre got busy=%b en=%b want 0/0", clear_busy, mem_en); end
        step();
        while (k < int'(MD) && cyc < 40) begin
            clear_start   = (cyc == 9);
            vga_req       = (cyc == 5);
            vga_addr      = 12'd100;
            cpu_req_valid = (cyc < 2);
            cpu_we        = (cyc == 0);
            cpu_addr      = 12'd3;
            cpu_wdata     = 8'h58;
            #1;
            total++; if (clear_busy !== 1'b1) begin bad++; $display("FAIL clear_busy_c%0d got=%b want=1", cyc, clear_busy); end
            if (vga_req) begin
                total++; if (mem_we !== 1'b0 || mem_addr !== 12'd100) begin bad++; $display("FAIL clear_vga_pause got we=%b addr=%0d want 0/100", mem_we, mem_addr); end
            end else begin
                total++; if ({mem_en, mem_we, mem_addr, mem_din} !== {1'b1, 1'b1, AW'(k), 8'h20}) begin bad++; $display("FAIL clear_write_%0d got=%b/%b/%0d/%h want=1/1/%0d/20", k, mem_en, mem_we, mem_addr, mem_din, k); end
                k++;
            end
            step();
            cyc++;
        end
        total++; if (k != int'(MD)) begin bad++; $display("FAIL clear_timeout got=%0d want=%0d", k, MD); end
        idle_inputs();
        #1;
        total++; if (clear_busy !== 1'b0) begin bad++; $display("FAIL clear_done_busy got=%b want=0", clear_busy); end
        total++; if ({mem_en, mem_we, mem_addr, mem_din} !== {1'b1, 1'b1, 12'd3, 8'h58}) begin bad++; $display("FAIL post_clear_write got=%b/%b/%0d/%h want=1/1/3/58", mem_en, mem_we, mem_addr, mem_din); end
        step();
        #1;
        total++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 12'd3}) begin bad++; $display("FAIL post_clear_read got=%b/%b/%0d want=1/0/3", mem_en, mem_we, mem_addr); end
        exp_cpu_q.push_back(8'h58);
        step();
        total++; if (cpu_rsp_valid !== 1'b1) begin bad++; $display("FAIL post_clear_rsp got=%b want=1", cpu_rsp_valid); end
        if (exp_cpu_q.size() > 0) begin
            e = exp_cpu_q.pop_front();
            total++; if (cpu_rdata !== e) begin bad++; $display("FAIL post_clear_data got=%h want=%h", cpu_rdata, e); end
        end
        step();
    endtask

    task automatic test_back_to_back();
        int sent;
        int cyc;
        logic vga_sent;
        logic [DW-1:0] e;
        sent = 0;
        cyc  = 0;
        while ((sent < 24 || exp_cpu_q.size() > 0) && cyc < 400) begin
            vga_req  = (sent < 24) && ($urandom_range(0, 2) == 0);
            vga_addr = AW'(100 + $urandom_range(0, 7));
            if (vga_req) exp_vga_q.push_back(ref_mem[vga_addr]);
            vga_sent = vga_req;
            if (sent < 24) begin
                cpu_req_valid = 1'($urandom_range(0, 1));
                cpu_we        = 1'($urandom_range(0, 1));
                cpu_addr      = AW'(200 + $urandom_range(0, 7));
                cpu_wdata     = DW'($urandom);
            end else begin
                cpu_req_valid = 1'b0;
            end
            #1;
            if (cpu_req_valid && cpu_req_ready) begin
                if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
                else        exp_cpu_q.push_back(ref_mem[cpu_addr]);
                sent++;
            end
            step();
            total++; if (vga_data_valid !== vga_sent) begin bad++; $display("FAIL b2b_vga_valid c%0d got=%b want=%b", cyc, vga_data_valid, vga_sent); end
            if (vga_data_valid && exp_vga_q.size() > 0) begin
                e = exp_vga_q.pop_front();
                total++; if (vga_data !== e) begin bad++; $display("FAIL b2b_vga_data c%0d got=%h want=%h", cyc, vga_data, e); end
            end
            if (cpu_rsp_valid) begin
                total++;
                if (exp_cpu_q.size() == 0) begin
                    bad++; $display("FAIL b2b_cpu_extra c%0d got rsp=%h want none", cyc, cpu_rdata);
                end else begin
                    e = exp_cpu_q.pop_front();
                    if (cpu_rdata !== e) begin bad++; $display("FAIL b2b_cpu_data c%0d got=%h want=%h", cyc, cpu_rdata, e); end
                end
            end
            cyc++;
        end
        idle_inputs();
        total++; if (exp_cpu_q.size() != 0 || sent != 24) begin bad++; $display("FAIL b2b_timeout got pending=%0d sent=%0d want 0/24", exp_cpu_q.size(), sent); end
        exp_cpu_q.delete();
        exp_vga_q.delete();
        step();
    endtask

    task automatic test_reset_mid();
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        for (int c = 0; c < 7; c++) begin
            cpu_req_valid = (c < 2);
            cpu_we        = 1'b1;
            cpu_addr      = AW'(30 + c);
            cpu_wdata     = 8'h77;
            step();
        end
        idle_inputs();
        #1;
        total++; if (mem_addr !== 12'd7 || clear_busy !== 1'b1) begin bad++; $display("FAIL mid_count got addr=%0d busy=%b want 7/1", mem_addr, clear_busy); end
        rst_n   = 1'b0;
        vga_req = 1'b1;
        step();
        rst_n   = 1'b1;
        vga_req = 1'b0;
        #1;
        total++; if (clear_busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", clear_busy); end
        total++; if (cpu_req_ready !== 1'b1 || mem_en !== 1'b0) begin bad++; $display("FAIL mid_fifo got ready=%b en=%b want 1/0", cpu_req_ready, mem_en); end
        total++; if (vga_data_valid !== 1'b0 || cpu_rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_strobes got=%b%b want=00", vga_data_valid, cpu_rsp_valid); end
        for (int c = 0; c < 3; c++) begin
            step();
            total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL mid_flushed_c%0d got en=%b want=0", c, mem_en); end
        end
        total++; if (ram[30] !== ref_mem[30]) begin bad++; $display("FAIL mid_no_write got=%h want=%h", ram[30], ref_mem[30]); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        ram[5] = 8'h41;
        for (int i = 0; i < 4; i++) ram[20 + i] = 8'h60 + 8'(i);

        test_reset();
        test_vga_read();
        test_cpu_under_vga();
        test_fifo_full();
        test_clear();
        test_back_to_back();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
